fma_dot_seq: RTL



---
 rtl/fma_dot_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fma_dot_seq.sv
// fma_dot_seq: sequencer that feeds one shared FP32 fused multiply-add
// (a*b + c) to accumulate a dot product over a streamed vector of pairs.
// One element is in flight at a time because each FMA consumes the previous
// result as its addend.
// Optional build macro: FMA_DOT_FLUSH_ZERO_EN flushes operands and FMA results
// whose exponent field is zero to +0.0 before they are registered.

module fma_dot_seq #(
  parameter int LEN_W   = 8,
  parameter int FMA_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      fma_a,
  output logic [31:0]      fma_b,
  output logic [31:0]      fma_c,
  input  logic [31:0]      fma_out,
  output logic [31:0]      result,
  output logic             result_valid,
  input  logic             result_ready
);

  // A 1-bit counter is kept even for a combinational FMA so the logic stays uniform
  localparam int LAT_W = (FMA_LAT > 0) ? $clog2(FMA_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_IN,
    S_EXEC,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [31:0]        a_reg;
  logic [31:0]        b_reg;
  logic [31:0]        acc;
  logic [LEN_W-1:0]   remaining;
  logic [LAT_W-1:0]   lat_cnt;
  logic               lat_done;
  logic               last_elem;

  // Denormal inputs (exponent field 0) become +0.0 so the FMA's exact-zero path fires
  function automatic logic [31:0] flush_denorm(input logic [31:0] x);
`ifdef FMA_DOT_FLUSH_ZERO_EN
    flush_denorm = (x[30:23] == 8'd0) ? 32'd0 : x;
`else
    flush_denorm = x;
`endif
  endfunction

  assign lat_done  = (lat_cnt == '0);
  assign last_elem = (remaining == LEN_W'(1));

  // Operands and addend come straight from registers so they stay stable in EXEC
  assign fma_a = a_reg;
  assign fma_b = b_reg;
  assign fma_c = acc;

  assign busy         = (state != S_IDLE);
  assign in_ready     = (state == S_WAIT_IN);
  assign result_valid = (state == S_DONE);
  assign result       = (state == S_DONE) ? acc : 32'd0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection; EXEC exits only once the latency counter has drained
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (len != '0) ? S_WAIT_IN : S_DONE;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (lat_done) begin
          state_next = last_elem ? S_DONE : S_WAIT_IN;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers: operand capture, latency countdown and accumulator write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      acc       <= 32'd0;
      remaining <= '0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc <= 32'd0;
            if (len != '0) begin
              remaining <= len;
            end
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            a_reg   <= flush_denorm(in_a);
            b_reg   <= flush_denorm(in_b);
            lat_cnt <= LAT_W'(FMA_LAT);
          end
        end
        S_EXEC: begin
          if (!lat_done) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            acc       <= flush_denorm(fma_out);
            remaining <= remaining - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
